// File: rtl/cnt_seg_scan.sv
// Two-digit, time-multiplexed common-anode 7-segment scanner for a 4-bit count (0..15).
// Latches the count once per frame, blanks both digits briefly after each switch, hides a leading zero.
module cnt_seg_scan #(
    parameter int SCAN_DIV  = 50000,
    parameter int BLANK_CYC = 4
) (
    input  logic       sys_clk,
    input  logic       sys_rst,
    input  logic [3:0] cnt,
    output logic [6:0] seg,
    output logic [1:0] sel
);

    localparam int DW = (SCAN_DIV > 2) ? $clog2(SCAN_DIV) : 1;
    localparam logic [DW-1:0] DIV_LAST = DW'(SCAN_DIV - 1);

    logic [DW-1:0] div_cnt_r;
    logic          digit_r;
    logic [3:0]    val_q_r;
    logic [6:0]    seg_r;
    logic [1:0]    sel_r;

    logic          in_blank_s;
    logic          tens_s;
    logic [3:0]    units_s;
    logic [6:0]    seg_nx_s;
    logic [1:0]    sel_nx_s;

    function automatic logic [6:0] seg_pattern(input logic [3:0] d);
        logic [6:0] p;
        case (d)
            4'd0:    p = 7'h40;
            4'd1:    p = 7'h79;
            4'd2:    p = 7'h24;
            4'd3:    p = 7'h30;
            4'd4:    p = 7'h19;
            4'd5:    p = 7'h12;
            4'd6:    p = 7'h02;
            4'd7:    p = 7'h78;
            4'd8:    p = 7'h00;
            4'd9:    p = 7'h10;
            default: p = 7'h7F;
        endcase
        return p;
    endfunction

    // With no blanking the window is empty; avoids a compare against a constant zero.
    generate
        if (BLANK_CYC == 0) begin : g_noblank
            assign in_blank_s = 1'b0;
        end else begin : g_blank
            localparam logic [DW-1:0] BLANK_LIM = DW'(BLANK_CYC);
            assign in_blank_s = (div_cnt_r < BLANK_LIM);
        end
    endgenerate

    assign tens_s  = (val_q_r >= 4'd10);
    assign units_s = tens_s ? (val_q_r - 4'd10) : val_q_r;

    // Slot divider, digit toggle and frame-boundary latch of the count.
    always_ff @(posedge sys_clk) begin
        if (sys_rst) begin
            div_cnt_r <= '0;
            digit_r   <= 1'b0;
            val_q_r   <= 4'd0;
        end else if (div_cnt_r == DIV_LAST) begin
            div_cnt_r <= '0;
            digit_r   <= ~digit_r;
            if (digit_r) begin
                val_q_r <= cnt;
            end else begin
                val_q_r <= val_q_r;
            end
        end else begin
            div_cnt_r <= div_cnt_r + DW'(1);
            digit_r   <= digit_r;
            val_q_r   <= val_q_r;
        end
    end

    // Next output drive; only one enable can ever be low.
    always_comb begin
        seg_nx_s = 7'h7F;
        sel_nx_s = 2'b11;
        if (in_blank_s) begin
            seg_nx_s = 7'h7F;
            sel_nx_s = 2'b11;
        end else if (!digit_r) begin
            seg_nx_s = seg_pattern(units_s);
            sel_nx_s = 2'b10;
        end else begin
            seg_nx_s = tens_s ? seg_pattern(4'd1) : 7'h7F;
            sel_nx_s = 2'b01;
        end
    end

    // Output registers.
    always_ff @(posedge sys_clk) begin
        if (sys_rst) begin
            seg_r <= 7'h7F;
            sel_r <= 2'b11;
        end else begin
            seg_r <= seg_nx_s;
            sel_r <= sel_nx_s;
        end
    end

    assign seg = seg_r;
    assign sel = sel_r;

endmodule

// File: tb/tb_cnt_seg_scan.sv
// Directed bench for cnt_seg_scan with a scoreboard; two instances (BLANK_CYC=2 and 0), SCAN_DIV=8.
module tb_cnt_seg_scan;

    logic       clk;
    logic       rst;
    logic [3:0] cnt;
    logic [6:0] seg_a, seg_b;
    logic [1:0] sel_a, sel_b;

    int n_assert = 0;
    int n_fail   = 0;

    int         mk;
    logic [3:0] mv;
    logic [8:0] q_a[$];
    logic [8:0] q_b[$];

    cnt_seg_scan #(.SCAN_DIV(8), .BLANK_CYC(2)) u_dut_a (
        .sys_clk(clk), .sys_rst(rst), .cnt(cnt), .seg(seg_a), .sel(sel_a)
    );

    cnt_seg_scan #(.SCAN_DIV(8), .BLANK_CYC(0)) u_dut_b (
        .sys_clk(clk), .sys_rst(rst), .cnt(cnt), .seg(seg_b), .sel(sel_b)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [6:0] pat(input int d);
        case (d)
            0: return 7'h40;
            1: return 7'h79;
            2: return 7'h24;
            3: return 7'h30;
            4: return 7'h19;
            5: return 7'h12;
            6: return 7'h02;
            7: return 7'h78;
            8: return 7'h00;
            9: return 7'h10;
            default: return 7'h7F;
        endcase
    endfunction

    function automatic logic [8:0] exp_out(input int k, input logic [3:0] v, input int blank);
        int pos, dig, u, t;
        pos = k % 8;
        dig = (k / 8) % 2;
        u   = int'(v) % 10;
        t   = int'(v) / 10;
        if (pos < blank) return {7'h7F, 2'b11};
        if (dig == 0) return {pat(u), 2'b10};
        return {(t != 0) ? pat(1) : 7'h7F, 2'b01};
    endfunction

    task automatic chk(input string tag, input logic [8:0] obs, input logic [8:0] exp_v);
        n_assert++;
        assert (obs === exp_v) else begin
            n_fail++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp_v);
        end
    endtask

    task automatic chk_sel(input string tag, input logic [1:0] s);
        n_assert++;
        assert (s !== 2'b00) else begin
            n_fail++;
            $error("FAIL %s: observed sel %b expected not 00", tag, s);
        end
    endtask

    // One clock: push expectations from the model, clock, then pop and compare.
    task automatic step();
        logic [8:0] ea, eb;
        if (rst) begin
            q_a.push_back({7'h7F, 2'b11});
            q_b.push_back({7'h7F, 2'b11});
        end else begin
            q_a.push_back(exp_out(mk, mv, 2));
            q_b.push_back(exp_out(mk, mv, 0));
        end
        @(posedge clk);
        #1;
        ea = q_a.pop_front();
        eb = q_b.pop_front();
        chk("sb_a", {seg_a, sel_a}, ea);
        chk("sb_b", {seg_b, sel_b}, eb);
        chk_sel("sel_a_legal", sel_a);
        chk_sel("sel_b_legal", sel_b);
        if (rst) begin
            mk = 0;
            mv = 4'd0;
        end else begin
            if (mk % 16 == 15) mv = cnt;
            mk = (mk + 1) % 16;
        end
    endtask

    // One aligned frame with directed spot checks; optional cnt change at step chg_i.
    task automatic run_frame(input logic [6:0] u, input logic [6:0] t, input int chg_i, input logic [3:0] chg_v);
        for (int i = 0; i < 16; i++) begin
            if (i == chg_i) cnt = chg_v;
            step();
            if (i == 0) begin
                chk("blank_a", {seg_a, sel_a}, {7'h7F, 2'b11});
                chk("units_b", {seg_b, sel_b}, {u, 2'b10});
            end
            if (i == 3)  chk("units_a", {seg_a, sel_a}, {u, 2'b10});
            if (i == 8)  chk("tens_b",  {seg_b, sel_b}, {t, 2'b01});
            if (i == 11) chk("tens_a",  {seg_a, sel_a}, {t, 2'b01});
        end
    endtask

    initial begin
        mk  = 0;
        mv  = 4'd0;
        rst = 1'b1;
        cnt = 4'd9;
        for (int i = 0; i < 5; i++) begin
            step();
            chk("rst_hold", {seg_a, sel_a}, {7'h7F, 2'b11});
        end
        rst = 1'b0;
        cnt = 4'd7;
        run_frame(7'h40, 7'h7F, -1, 4'd0);
        run_frame(7'h78, 7'h7F, -1, 4'd0);
        cnt = 4'd13;
        run_frame(7'h78, 7'h7F, -1, 4'd0);
        run_frame(7'h30, 7'h79, -1, 4'd0);
        cnt = 4'd3;
        run_frame(7'h30, 7'h79, -1, 4'd0);
        run_frame(7'h30, 7'h7F, 4, 4'd12);
        cnt = 4'd15;
        run_frame(7'h24, 7'h79, -1, 4'd0);
        cnt = 4'd0;
        run_frame(7'h12, 7'h79, -1, 4'd0);
        cnt = 4'd9;
        run_frame(7'h40, 7'h7F, -1, 4'd0);
        // Stop at div_cnt=5 of the tens slot, then reset mid-frame.
        for (int i = 0; i < 13; i++) step();
        rst = 1'b1;
        step();
        chk("midrst_a", {seg_a, sel_a}, {7'h7F, 2'b11});
        chk("midrst_b", {seg_b, sel_b}, {7'h7F, 2'b11});
        rst = 1'b0;
        run_frame(7'h40, 7'h7F, -1, 4'd0);
        run_frame(7'h10, 7'h7F, -1, 4'd0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule

// File: doc/cnt_seg_scan.md
Name: cnt_seg_scan

Overview:
- Display stage directly downstream of the up/down counter (cnt_ud); consumes its 4-bit count value.
- Shows the value as decimal 0–15 on a two-digit, time-multiplexed, common-anode 7-segment display.
- Latches the input once per scan frame so a digit never tears mid-frame.
- Blanks both digit enables for a short window after every digit switch (anti-ghosting) and suppresses a leading-zero tens digit.

Parameters:
- SCAN_DIV, 50000, clock cycles each digit is shown; must be >= BLANK_CYC+1 and >= 2.
- BLANK_CYC, 4, cycles at the start of each digit slot with both digit enables off; 0 disables blanking.

Ports:
- sys_clk  input  1  system clock; all logic on rising edge.
- sys_rst  input  1  synchronous, active-high reset.
- cnt  input  4  unsigned value from the upstream counter; sampled only at frame boundaries.
- seg  output  7  segment drive, active low; seg[0]=a … seg[6]=g; registered.
- sel  output  2  digit enable, active low; sel[0]=units, sel[1]=tens; registered.

Behaviour:
- Reset: when sys_rst=1 at a rising edge, the state after that edge is:
  - div_cnt=0, digit=0 (units), val_q=0.
  - seg=7'h7F (all off), sel=2'b11 (both off).
- Divider: div_cnt counts 0..SCAN_DIV-1 and wraps to 0.
  - At the wrap, digit toggles (0→1, 1→0).
  - One frame = 2*SCAN_DIV cycles.
- Frame latch: at the edge where div_cnt==SCAN_DIV-1 and digit==1, val_q <= cnt.
  - The new value first appears in the units slot that starts on the next cycle.
  - cnt changes at any other time have no visible effect until the next frame boundary.
  - The first frame after reset always shows val_q=0.
- Decode, combinational from val_q:
  - tens = (val_q >= 10) ? 1 : 0.
  - units = val_q - 10*tens (4-bit, 0..9).
- Segment patterns, active low, seg[6:0]:
  - 0=40, 1=79, 2=24, 3=30, 4=19, 5=12, 6=02, 7=78, 8=00, 9=10 (hex); blank=7F.
- Leading zero: when tens==0 the tens slot outputs seg=7F. sel still enables the tens digit outside the blank window.
- Output timing: outputs are registered from the current (div_cnt, digit, val_q), one-cycle latency.
  - If div_cnt < BLANK_CYC: sel=11, seg=7F.
  - Otherwise, digit 0: sel=10, seg=pattern(units).
  - Otherwise, digit 1: sel=01, seg=pattern(tens) or blank.
- Never assert both digit enables at once; sel=00 is illegal in every state.
- Reset mid-frame: the divider, digit and latch restart immediately; outputs are off on the cycle after the reset edge. No partial-frame state survives.
- cnt is assumed synchronous to sys_clk (produced by the counter on the same clock); no input synchronizer.

Test Plan:
- All scenarios use SCAN_DIV=8, BLANK_CYC=2 unless stated; frame = 16 cycles.
- Reset hold: sys_rst=1 for 5 cycles with cnt=9 → seg=7F, sel=11 every cycle; first frame after release shows units "0" (seg=40 when sel=10), tens slot seg=7F.
- Steady cnt=7 from reset release → from the second frame onward:
  - units slot: 2 cycles sel=11/seg=7F, then 6 cycles sel=10/seg=78;
  - tens slot: 2 cycles off, then 6 cycles sel=01/seg=7F.
- cnt=13 steady → units slot seg=30 with sel=10; tens slot seg=79 with sel=01; pattern repeats every 16 cycles.
- cnt steps 3→12 at div_cnt=4 of a units slot → remainder of that frame still shows 3 (seg=30); the following frame shows units 2 (seg=24) and tens 1 (seg=79).
- Counter wrap: cnt driven 15→0 across frames → frame with 15 shows seg=12 (units) and 79 (tens); next frame shows seg=40 (units) and 7F (tens).
- Reset at div_cnt=5 of a tens slot → next cycle sel=11/seg=7F; digit restarts at units; val_q=0.
- Across all cycles, the checker asserts sel != 00.
- Also run with BLANK_CYC=0: no off cycles after the first frame.
